// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: WIDTH-bit adder built from one reused 2-bit slice, two bits per clock, start/ready/done handshake
module two_bit_adder (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       ci,
  output logic [1:0] s,
  output logic       co
);
  logic c0;
  assign s[0] = a[0] ^ b[0] ^ ci;
  assign c0   = (a[0] & b[0]) | (ci & (a[0] ^ b[0]));
  assign s[1] = a[1] ^ b[1] ^ c0;
  assign co   = (a[1] & b[1]) | (c0 & (a[1] ^ b[1]));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int N = WIDTH / 2;
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state, state_n;
  logic [SW-1:0] step;
  logic [SW:0] idx;
  logic [WIDTH-1:0] opa, opb, acc, acc_n;
  logic carry, c1, accept, last;
  logic [1:0] s;
  two_bit_adder u_slice (.a(opa[1:0]), .b(opb[1:0]), .ci(carry), .s(s), .co(c1));
  assign ready  = state != ADD;
  assign busy   = state == ADD;
  assign done   = state == DONE;
  assign accept = ready && start;
  assign last   = step == SW'(N - 1);
  assign idx    = {step, 1'b0};
  always_comb begin
    state_n = accept ? ADD : (busy ? (last ? DONE : ADD) : IDLE);
    acc_n = acc;
    acc_n[idx +: 2] = s;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      step  <= '0;
      carry <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        opa   <= a;
        opb   <= b;
        carry <= cin;
        step  <= '0;
      end else if (busy) begin
        opa   <= opa >> 2;
        opb   <= opb >> 2;
        carry <= c1;
        acc   <= acc_n;
        step  <= last ? '0 : step + 1'b1;
        if (last) begin
          sum  <= acc_n;
          cout <= c1;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed self-checking bench for 8-bit and 2-bit serial adder instances
module tb_serial_adder_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic start8 = 1'b0, cin8 = 1'b0, ready8, busy8, done8, cout8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic start2 = 1'b0, cin2 = 1'b0, ready2, busy2, done2, cout2;
  logic [1:0] a2 = '0, b2 = '0, sum2;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  serial_adder_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_adder_ctrl #(.WIDTH(2)) u2 (
    .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .ready(ready2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic op(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic ci,
                    input logic [7:0] es, input logic ec);
    int n;
    a8 = av; b8 = bv; cin8 = ci; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    chk({tag, "_busy"}, busy8, 1);
    n = 0;
    while (!done8 && n < 20) begin
      n++;
      tick;
    end
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_done"}, done8, 1);
    chk({tag, "_sum"}, sum8, es);
    chk({tag, "_cout"}, cout8, ec);
    tick;
    chk({tag, "_pulse"}, done8, 0);
    chk({tag, "_idle"}, ready8, 1);
  endtask
  initial begin
    int m;
    tick;
    tick;
    reset = 1'b0;
    chk("rst_ready", ready8, 1);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_sum", sum8, 0);
    chk("rst_cout", cout8, 0);
    chk("rst_ready2", ready2, 1);
    op("t5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    op("tff00", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
    op("tffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    tick;
    tick;
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
    chk("ign_busy", busy8, 1);
    tick;
    a8 = 8'h33; b8 = 8'hCC;
    chk("ign_nodone", done8, 0);
    tick;
    start8 = 1'b0;
    chk("ign_done", done8, 1);
    chk("ign_sum", sum8, 8'h03);
    chk("ign_cout", cout8, 0);
    tick;
    chk("ign_pulse", done8, 0);
    chk("ign_notbusy", busy8, 0);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("abort_ready", ready8, 1);
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_sum", sum8, 0);
    chk("abort_cout", cout8, 0);
    tick;
    chk("abort_nodone", done8, 0);
    op("t8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    tick;
    m = 0;
    while (!done8 && m < 20) begin
      m++;
      tick;
    end
    chk("b2b_lat1", m, 4);
    chk("b2b_sum1", sum8, 8'h30);
    chk("b2b_cout1", cout8, 0);
    a8 = 8'h7F; b8 = 8'h01;
    m = 0;
    do begin
      tick;
      m++;
      if (!done8) chk("b2b_hold", sum8, 8'h30);
    end while (!done8 && m < 20);
    start8 = 1'b0;
    chk("b2b_gap", m, 5);
    chk("b2b_sum2", sum8, 8'h80);
    chk("b2b_cout2", cout8, 0);
    tick;
    chk("b2b_pulse", done8, 0);
    a2 = 2'd3; b2 = 2'd3; cin2 = 1'b1; start2 = 1'b1;
    tick;
    start2 = 1'b0;
    chk("w2_busy", busy2, 1);
    tick;
    chk("w2_done", done2, 1);
    chk("w2_sum", sum2, 2'd3);
    chk("w2_cout", cout2, 1);
    tick;
    chk("w2_pulse", done2, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
